// File: rtl/nes_debugger_mem_arbiter.sv
// nes_debugger_mem_arbiter
// Shares NUM_POOLS backing memories between the NES core and the debugger.
// The NES always owns a pool when it asks for it; a single debugger access
// waits in a holding register and slips into the first cycle its pool is free.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | ready for a debugger request
// ST_PENDING | holding an access, driving the pool whenever the NES is idle
// ST_WAIT    | read issued, counting down the memory latency
// ST_DONE    | completion strobe
// ST_ERROR   | bad-pool strobe, nothing was issued
// ST_ABORT   | timeout strobe, nothing was issued
module nes_debugger_mem_arbiter #(
  parameter int NUM_POOLS      = 4,
  parameter int POOL_SEL_WIDTH = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int MEM_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [NUM_POOLS-1:0]             i_nes_en,
  input  logic [NUM_POOLS-1:0]             i_nes_rw,
  input  logic [NUM_POOLS*ADDR_WIDTH-1:0]  i_nes_address,
  input  logic [NUM_POOLS*DATA_WIDTH-1:0]  i_nes_data,
  output logic [NUM_POOLS*DATA_WIDTH-1:0]  o_nes_data,
  input  logic                             i_dbg_req,
  input  logic                             i_dbg_rw,
  input  logic [POOL_SEL_WIDTH-1:0]        i_dbg_pool,
  input  logic [ADDR_WIDTH-1:0]            i_dbg_address,
  input  logic [DATA_WIDTH-1:0]            i_dbg_data,
  output logic                             o_dbg_ready,
  output logic                             o_dbg_done,
  output logic [DATA_WIDTH-1:0]            o_dbg_data,
  output logic                             o_dbg_timeout,
  output logic                             o_dbg_error,
  output logic [NUM_POOLS-1:0]             o_mem_en,
  output logic [NUM_POOLS-1:0]             o_mem_wea,
  output logic [NUM_POOLS*ADDR_WIDTH-1:0]  o_mem_address,
  output logic [NUM_POOLS*DATA_WIDTH-1:0]  o_mem_data,
  input  logic [NUM_POOLS*DATA_WIDTH-1:0]  i_mem_data
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PENDING = 3'd1;
  localparam logic [2:0] ST_WAIT    = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;
  localparam logic [2:0] ST_ABORT   = 3'd5;

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [2:0]                    state_q, state_d;
  logic [POOL_SEL_WIDTH-1:0]     hold_pool_q, hold_pool_d;
  logic                          hold_rw_q, hold_rw_d;
  logic [ADDR_WIDTH-1:0]         hold_addr_q, hold_addr_d;
  logic [DATA_WIDTH-1:0]         hold_data_q, hold_data_d;
  logic [LAT_W-1:0]              lat_cnt_q, lat_cnt_d;
  logic [TMO_W-1:0]              tmo_cnt_q, tmo_cnt_d;
  logic [DATA_WIDTH-1:0]         dbg_data_q, dbg_data_d;
  logic [NUM_POOLS*DATA_WIDTH-1:0] nes_data_q, nes_data_d;
  logic [NUM_POOLS-1:0]          nes_rd_pipe_q [MEM_LATENCY];
  logic [NUM_POOLS-1:0]          nes_rd_pipe_d [MEM_LATENCY];

  logic [NUM_POOLS-1:0]          pool_sel;
  logic                          pool_busy;
  logic                          bad_pool;
  logic [DATA_WIDTH-1:0]         held_rdata;

  // Decode the held pool and pick out its NES activity and read data
  always_comb begin
    pool_sel   = '0;
    held_rdata = '0;
    for (int p = 0; p < NUM_POOLS; p++) begin
      pool_sel[p] = (hold_pool_q == POOL_SEL_WIDTH'(p));
      if (pool_sel[p]) held_rdata = i_mem_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
    pool_busy = |(i_nes_en & pool_sel);
    bad_pool  = (int'(i_dbg_pool) >= NUM_POOLS);
  end

  // Debugger access sequencing; the timeout is a down-counter that stops at 1
  always_comb begin
    state_d     = state_q;
    hold_pool_d = hold_pool_q;
    hold_rw_d   = hold_rw_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    lat_cnt_d   = lat_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    dbg_data_d  = dbg_data_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dbg_req) begin
          hold_pool_d = i_dbg_pool;
          hold_rw_d   = i_dbg_rw;
          hold_addr_d = i_dbg_address;
          hold_data_d = i_dbg_data;
          tmo_cnt_d   = TMO_W'(TIMEOUT_CYCLES);
          state_d     = bad_pool ? ST_ERROR : ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (!pool_busy) begin
          if (hold_rw_q) begin
            lat_cnt_d = LAT_W'(MEM_LATENCY - 1);
            state_d   = ST_WAIT;
          end else begin
            state_d = ST_DONE;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          if (tmo_cnt_q <= TMO_W'(1)) state_d = ST_ABORT;
          else tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == '0) begin
          dbg_data_d = held_rdata;
          state_d    = ST_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      ST_DONE, ST_ERROR, ST_ABORT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NES read tracking: capture pool data as each issued read leaves the pipe
  always_comb begin
    nes_rd_pipe_d[0] = i_nes_en & i_nes_rw;
    for (int i = 1; i < MEM_LATENCY; i++) nes_rd_pipe_d[i] = nes_rd_pipe_q[i-1];
    nes_data_d = nes_data_q;
    for (int p = 0; p < NUM_POOLS; p++) begin
      if (nes_rd_pipe_q[MEM_LATENCY-1][p])
        nes_data_d[p*DATA_WIDTH +: DATA_WIDTH] = i_mem_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Per-pool memory port: NES first, then a pending debugger access
  always_comb begin
    o_mem_en      = '0;
    o_mem_wea     = '0;
    o_mem_address = '0;
    o_mem_data    = '0;
    for (int p = 0; p < NUM_POOLS; p++) begin
      if (i_nes_en[p]) begin
        o_mem_en[p]                               = 1'b1;
        o_mem_wea[p]                              = ~i_nes_rw[p];
        o_mem_address[p*ADDR_WIDTH +: ADDR_WIDTH] = i_nes_address[p*ADDR_WIDTH +: ADDR_WIDTH];
        o_mem_data[p*DATA_WIDTH +: DATA_WIDTH]    = i_nes_data[p*DATA_WIDTH +: DATA_WIDTH];
      end else if (state_q == ST_PENDING && pool_sel[p]) begin
        o_mem_en[p]                               = 1'b1;
        o_mem_wea[p]                              = ~hold_rw_q;
        o_mem_address[p*ADDR_WIDTH +: ADDR_WIDTH] = hold_addr_q;
        o_mem_data[p*DATA_WIDTH +: DATA_WIDTH]    = hold_data_q;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      hold_pool_q <= '0;
      hold_rw_q   <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      lat_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      dbg_data_q  <= '0;
      nes_data_q  <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) nes_rd_pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      hold_pool_q <= hold_pool_d;
      hold_rw_q   <= hold_rw_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      lat_cnt_q   <= lat_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      dbg_data_q  <= dbg_data_d;
      nes_data_q  <= nes_data_d;
      for (int i = 0; i < MEM_LATENCY; i++) nes_rd_pipe_q[i] <= nes_rd_pipe_d[i];
    end
  end

  assign o_dbg_ready   = (state_q == ST_IDLE);
  assign o_dbg_done    = (state_q == ST_DONE);
  assign o_dbg_error   = (state_q == ST_ERROR);
  assign o_dbg_timeout = (state_q == ST_ABORT);
  assign o_dbg_data    = dbg_data_q;
  assign o_nes_data    = nes_data_q;

endmodule

// File: tb/tb_nes_debugger_mem_arbiter.sv
// Bench for nes_debugger_mem_arbiter: three pools, two-cycle memory, short timeout.
// Expectations come from a window-indexed model: each access gets a predicted
// issue window and strobe window from the NES-busy pattern the bench drives.
module tb_nes_debugger_mem_arbiter;
  localparam int NP  = 3;
  localparam int PSW = 2;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int TO  = 8;

  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_TMO  = 2;
  localparam int K_ERR  = 3;

  logic              i_clk = 1'b0;
  logic              i_reset_n;
  logic [NP-1:0]     i_nes_en, i_nes_rw;
  logic [NP*AW-1:0]  i_nes_address;
  logic [NP*DW-1:0]  i_nes_data, o_nes_data;
  logic              i_dbg_req, i_dbg_rw;
  logic [PSW-1:0]    i_dbg_pool;
  logic [AW-1:0]     i_dbg_address;
  logic [DW-1:0]     i_dbg_data;
  logic              o_dbg_ready, o_dbg_done, o_dbg_timeout, o_dbg_error;
  logic [DW-1:0]     o_dbg_data;
  logic [NP-1:0]     o_mem_en, o_mem_wea;
  logic [NP*AW-1:0]  o_mem_address;
  logic [NP*DW-1:0]  o_mem_data, i_mem_data;

  always #5 i_clk = ~i_clk;

  nes_debugger_mem_arbiter #(
    .NUM_POOLS(NP), .POOL_SEL_WIDTH(PSW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .MEM_LATENCY(LAT), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_nes_en(i_nes_en), .i_nes_rw(i_nes_rw), .i_nes_address(i_nes_address),
    .i_nes_data(i_nes_data), .o_nes_data(o_nes_data),
    .i_dbg_req(i_dbg_req), .i_dbg_rw(i_dbg_rw), .i_dbg_pool(i_dbg_pool),
    .i_dbg_address(i_dbg_address), .i_dbg_data(i_dbg_data),
    .o_dbg_ready(o_dbg_ready), .o_dbg_done(o_dbg_done), .o_dbg_data(o_dbg_data),
    .o_dbg_timeout(o_dbg_timeout), .o_dbg_error(o_dbg_error),
    .o_mem_en(o_mem_en), .o_mem_wea(o_mem_wea), .o_mem_address(o_mem_address),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data)
  );

  typedef struct {
    int         due;
    int         pool;
    logic [7:0] val;
  } nes_exp_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         win = 0;
  logic [7:0] mem [NP][65536];
  logic [7:0] rd_pipe [NP][LAT];
  logic [7:0] ref_mem [NP][256];
  logic [7:0] exp_nes [NP];
  logic [7:0] exp_dbg_data;
  nes_exp_t   nes_q[$];

  int          acc_win, end_win, issue_win, end_kind, m_pool;
  logic        m_rw;
  logic [15:0] m_addr;
  logic [7:0]  m_data;

  function automatic logic [7:0] pat(input int p, input int a);
    return 8'(a ^ (a >> 5) ^ (p * 37));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_window();
    logic [31:0] e, o;
    for (int p = 0; p < NP; p++) begin
      if (i_nes_en[p])
        e = {6'd0, 1'b1, ~i_nes_rw[p], i_nes_address[p*AW +: AW], i_nes_data[p*DW +: DW]};
      else if (p == m_pool && win == issue_win)
        e = {6'd0, 1'b1, ~m_rw, m_addr, m_data};
      else
        e = '0;
      o = {6'd0, o_mem_en[p], o_mem_wea[p], o_mem_address[p*AW +: AW], o_mem_data[p*DW +: DW]};
      chk($sformatf("mux_p%0d_w%0d", p, win), o, e);
    end
    e = {28'd0, !(win > acc_win && win <= end_win),
         (win == end_win && end_kind == K_DONE),
         (win == end_win && end_kind == K_TMO),
         (win == end_win && end_kind == K_ERR)};
    o = {28'd0, o_dbg_ready, o_dbg_done, o_dbg_timeout, o_dbg_error};
    chk($sformatf("rdy_done_tmo_err_w%0d", win), o, e);
    if (win == end_win && end_kind == K_DONE && m_rw)
      exp_dbg_data = ref_mem[m_pool][m_addr[7:0]];
    chk($sformatf("dbg_data_w%0d", win), {24'd0, o_dbg_data}, {24'd0, exp_dbg_data});
    for (int p = 0; p < NP; p++)
      chk($sformatf("nes_data_p%0d_w%0d", p, win), {24'd0, o_nes_data[p*DW +: DW]}, {24'd0, exp_nes[p]});
    if (win == issue_win && !m_rw) ref_mem[m_pool][m_addr[7:0]] = m_data;
  endtask

  // One clock window: check, model the memories, advance past the edge.
  task automatic tick();
    logic [7:0] rdv [NP];
    #1;
    check_window();
    for (int p = 0; p < NP; p++) begin
      rdv[p] = 8'($urandom);
      if (o_mem_en[p]) begin
        if (o_mem_wea[p]) mem[p][o_mem_address[p*AW +: AW]] = o_mem_data[p*DW +: DW];
        else rdv[p] = mem[p][o_mem_address[p*AW +: AW]];
      end
      if (i_nes_en[p] && i_nes_rw[p] && i_reset_n)
        nes_q.push_back('{win + LAT + 1, p, pat(p, int'(i_nes_address[p*AW +: AW]))});
    end
    @(posedge i_clk);
    #1;
    win++;
    for (int p = 0; p < NP; p++) begin
      for (int i = LAT - 1; i > 0; i--) rd_pipe[p][i] = rd_pipe[p][i-1];
      rd_pipe[p][0] = rdv[p];
      i_mem_data[p*DW +: DW] = rd_pipe[p][LAT-1];
    end
    while (nes_q.size() > 0 && nes_q[0].due <= win) begin
      exp_nes[nes_q[0].pool] = nes_q[0].val;
      void'(nes_q.pop_front());
    end
  endtask

  task automatic drive_nes(input int target, input logic busy);
    for (int p = 0; p < NP; p++) begin
      int r;
      r = $urandom_range(0, 3);
      i_nes_address[p*AW +: AW] = 16'h8000 | 16'($urandom_range(0, 255));
      i_nes_data[p*DW +: DW]    = 8'($urandom);
      if (p == target) begin
        i_nes_en[p] = busy;
        i_nes_rw[p] = 1'b1;
      end else begin
        i_nes_en[p] = (r >= 2);
        i_nes_rw[p] = (r != 3);
        if (r == 3) i_nes_address[p*AW +: AW] = 16'h4000 | 16'($urandom_range(0, 255));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_dbg_req = 1'b0;
      drive_nes(-1, 1'b0);
      tick();
    end
  endtask

  // k = windows the NES keeps the target pool busy after the accept
  task automatic access(input logic rw, input int pool, input logic [7:0] a8,
                        input logic [7:0] d, input int k, input int stop_after,
                        input logic [63:0] force_busy);
    logic [63:0] mask;
    mask = {$urandom, $urandom} | force_busy;
    for (int i = 0; i < 64; i++) if (i < k) mask[i] = 1'b1;
    if (k < 64) mask[k] = 1'b0;
    acc_win = win;
    m_pool  = pool;
    m_rw    = rw;
    m_addr  = 16'h0100 | 16'(a8);
    m_data  = d;
    if (pool >= NP) begin
      end_kind = K_ERR;  end_win = acc_win + 1;  issue_win = -100;
    end else if (TO > 0 && k >= TO) begin
      end_kind = K_TMO;  end_win = acc_win + 1 + TO;  issue_win = -100;
    end else begin
      end_kind  = K_DONE;
      issue_win = acc_win + 1 + k;
      end_win   = issue_win + 1 + (rw ? LAT : 0);
    end
    i_dbg_req = 1'b1;  i_dbg_rw = rw;  i_dbg_pool = PSW'(pool);
    i_dbg_address = m_addr;  i_dbg_data = d;
    drive_nes(-1, 1'b0);
    tick();
    while (win <= end_win && !(stop_after >= 0 && win >= acc_win + 1 + stop_after)) begin
      drive_nes((pool < NP) ? pool : -1, mask[win - acc_win - 1]);
      i_dbg_req     = 1'($urandom_range(0, 1));
      i_dbg_rw      = 1'($urandom_range(0, 1));
      i_dbg_pool    = PSW'($urandom_range(0, 3));
      i_dbg_address = 16'($urandom);
      i_dbg_data    = 8'($urandom);
      tick();
    end
    i_dbg_req = 1'b0;
  endtask

  task automatic model_reset();
    acc_win = -100;  end_win = -100;  issue_win = -100;
    end_kind = K_NONE;  m_pool = -1;
    exp_dbg_data = '0;
    for (int p = 0; p < NP; p++) exp_nes[p] = '0;
    nes_q.delete();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"},   {31'd0, o_dbg_ready},   32'd1);
    chk({tag, "_strobes"}, {29'd0, o_dbg_done, o_dbg_timeout, o_dbg_error}, 32'd0);
    chk({tag, "_dbgdata"}, {24'd0, o_dbg_data},    32'd0);
    chk({tag, "_nesdata"}, {8'd0, o_nes_data},     32'd0);
    chk({tag, "_memen"},   {29'd0, o_mem_en},      32'd0);
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      for (int a = 0; a < 65536; a++) mem[p][a] = pat(p, a);
      for (int a = 0; a < 256; a++) ref_mem[p][a] = pat(p, 16'h0100 | a);
      for (int i = 0; i < LAT; i++) rd_pipe[p][i] = '0;
    end
    i_reset_n = 1'b0;
    i_nes_en = '0;  i_nes_rw = '0;  i_nes_address = '0;  i_nes_data = '0;
    i_dbg_req = 1'b0;  i_dbg_rw = 1'b0;  i_dbg_pool = '0;
    i_dbg_address = '0;  i_dbg_data = '0;  i_mem_data = '0;
    m_rw = 1'b0;  m_addr = '0;  m_data = '0;
    model_reset();
    #2;
    check_reset_values("por");
    tick();
    tick();
    i_reset_n = 1'b1;
    idle(3);

    // write 0x5A to pool 1 / 0x0123, read it back
    access(1'b0, 1, 8'h23, 8'h5A, 0, -1, 64'd0);
    idle(1);
    access(1'b1, 1, 8'h23, 8'h00, 0, -1, 64'd0);
    chk("t1_readback", {24'd0, o_dbg_data}, 32'h5A);
    idle(2);
    // read of pool 0 held off by NES traffic for 7 cycles
    access(1'b1, 0, 8'h40, 8'h00, 7, -1, 64'd0);
    idle(2);
    // pool 2 never frees up: timeout
    access(1'b0, 2, 8'h10, 8'hAA, 20, -1, 64'd0);
    idle(2);
    // pool index beyond NUM_POOLS
    access(1'b1, 3, 8'h00, 8'h00, 0, -1, 64'd0);
    idle(2);
    // debugger read with a NES read of the same pool two cycles after accept
    access(1'b1, 1, 8'h77, 8'h00, 0, -1, 64'h2);
    idle(2);

    // reset in the middle of a read's latency wait
    access(1'b1, 0, 8'h55, 8'h00, 0, 2, 64'd0);
    i_reset_n = 1'b0;
    i_nes_en  = '0;
    i_dbg_req = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    tick();
    i_reset_n = 1'b1;
    idle(6);

    for (int n = 0; n < 40; n++) begin
      access(1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0) ? $urandom_range(8, 12) : $urandom_range(0, 5),
             -1, 64'd0);
      idle($urandom_range(0, 3));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
